wb_regfile: RTL and testbench

- Write-back end of the pipeline: consumes the MEM/WB register outputs (GPR write address/enable/data, HI/LO values and write enable) and commits them to architectural state.
- Holds the 32-entry general-purpose register file and the HI/LO register pair.
- Serves two combinational GPR read ports to the ID stage, plus HI/LO read-out to EX, with same-cycle write-through bypass so a write-back and an ID read of the same register in one cycle return the new value.

---
 rtl/wb_regfile_if.sv | 42 ++++
 rtl/wb_regfile.sv | 83 ++++++++
 tb/tb_wb_regfile.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// wb_regfile_if
// Bundles the write-back commit signals from MEM/WB, the two ID-stage GPR
// read ports and the HI/LO read-out towards EX.
//   master : pipeline side (drives write/read requests, receives read data)
//   slave  : register file side
// Ports (all widths from DATA_W / ADDR_W):
//   we, waddr, wdata      GPR write-back
//   whilo, hi_i, lo_i     HI/LO write-back
//   re1, raddr1, rdata1   GPR read port 1
//   re2, raddr2, rdata2   GPR read port 2
//   hi_o, lo_o            current HI/LO (bypassed)
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              whilo;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output we, waddr, wdata, whilo, hi_i, lo_i,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  we, waddr, wdata, whilo, hi_i, lo_i,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile
// Write-back stage architectural state: 32 GPRs plus the HI/LO pair.
// Commits MEM/WB results on the rising clock edge and serves two
// combinational GPR read ports (ID) and HI/LO read-out (EX), each with a
// same-cycle write-through bypass.
// Ports:
//   clk  system clock, state updates on rising edge
//   rst  asynchronous active-high reset; clears all state, zeroes outputs
//   bus  wb_regfile_if.slave (write-back, read ports, HI/LO out)
// NUM_REGS must equal 2**ADDR_W.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic          clk,
  input  logic          rst,
  wb_regfile_if.slave   bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // regs[0] is only ever cleared, so it reads back as a hard zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we && (bus.waddr != '0)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (bus.whilo) begin
      hi_q <= bus.hi_i;
      lo_q <= bus.lo_i;
    end
  end

  // Address 0 wins over the bypass so a discarded write to r0 never leaks.
  always_comb begin
    bus.rdata1 = '0;
    if (!rst && (bus.raddr1 != '0) && bus.re1) begin
      if (bus.we && (bus.raddr1 == bus.waddr)) begin
        bus.rdata1 = bus.wdata;
      end else begin
        bus.rdata1 = regs[bus.raddr1];
      end
    end
  end

  always_comb begin
    bus.rdata2 = '0;
    if (!rst && (bus.raddr2 != '0) && bus.re2) begin
      if (bus.we && (bus.raddr2 == bus.waddr)) begin
        bus.rdata2 = bus.wdata;
      end else begin
        bus.rdata2 = regs[bus.raddr2];
      end
    end
  end

  always_comb begin
    bus.hi_o = '0;
    bus.lo_o = '0;
    if (!rst) begin
      if (bus.whilo) begin
        bus.hi_o = bus.hi_i;
        bus.lo_o = bus.lo_i;
      end else begin
        bus.hi_o = hi_q;
        bus.lo_o = lo_q;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
// Directed vector table for wb_regfile plus hand-written reset sequences.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.we     = v.we;
    bus.waddr  = v.waddr;
    bus.wdata  = v.wdata;
    bus.whilo  = v.whilo;
    bus.hi_i   = v.hi_i;
    bus.lo_i   = v.lo_i;
    bus.re1    = v.re1;
    bus.raddr1 = v.raddr1;
    bus.re2    = v.re2;
    bus.raddr2 = v.raddr2;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'h0;
    bus.whilo = 1'b0; bus.hi_i = 32'h0; bus.lo_i = 32'h0;
    bus.re1 = 1'b0; bus.raddr1 = 5'd0; bus.re2 = 1'b0; bus.raddr2 = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Each vector: inputs applied after a negedge, outputs checked before the
    // following posedge, which then commits the write.
    //            we    waddr  wdata          whilo hi_i           lo_i           re1   ra1    re2   ra2    e_r1           e_r2           e_hi           e_lo
    vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 32'h0,         32'h0,         1'b1, 5'd3,  1'b1, 5'd4,  32'hDEADBEEF, 32'h0,         32'h0,         32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,         32'h0,         1'b1, 5'd3,  1'b0, 5'd3,  32'hDEADBEEF, 32'h0,         32'h0,         32'h0};
    vecs[2]  = '{1'b1, 5'd7,  32'h11111111, 1'b0, 32'h0,         32'h0,         1'b0, 5'd3,  1'b1, 5'd3,  32'h0,        32'hDEADBEEF, 32'h0,         32'h0};
    vecs[3]  = '{1'b1, 5'd7,  32'h22222222, 1'b0, 32'h0,         32'h0,         1'b1, 5'd7,  1'b1, 5'd7,  32'h22222222, 32'h22222222, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,         32'h0,         1'b1, 5'd7,  1'b1, 5'd7,  32'h22222222, 32'h22222222, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h0,         32'h0,         1'b1, 5'd0,  1'b1, 5'd3,  32'h0,        32'hDEADBEEF, 32'h0,         32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hAAAA0000,  32'h0000BBBB,  1'b1, 5'd0,  1'b1, 5'd7,  32'h0,        32'h22222222, 32'hAAAA0000,  32'h0000BBBB};
    vecs[7]  = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 32'h12345678,  32'h0,         1'b1, 5'd31, 1'b0, 5'd0,  32'hCAFEF00D, 32'h0,         32'hAAAA0000,  32'h0000BBBB};
    vecs[8]  = '{1'b1, 5'd1,  32'h00000001, 1'b1, 32'h00000001,  32'h00000002,  1'b1, 5'd1,  1'b1, 5'd31, 32'h00000001, 32'hCAFEF00D, 32'h00000001,  32'h00000002};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,         32'h0,         1'b1, 5'd1,  1'b1, 5'd7,  32'h00000001, 32'h22222222, 32'h00000001,  32'h00000002};
    vecs[10] = '{1'b1, 5'd3,  32'h0,        1'b0, 32'h0,         32'h0,         1'b1, 5'd4,  1'b1, 5'd3,  32'h0,        32'h0,         32'h00000001,  32'h00000002};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,         32'h0,         1'b1, 5'd3,  1'b1, 5'd31, 32'h0,        32'hCAFEF00D, 32'h00000001,  32'h00000002};

    // Reset: outputs forced to zero, writes during reset ignored.
    idle();
    rst = 1'b1;
    @(negedge clk);
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h55AA55AA;
    bus.whilo = 1'b1; bus.hi_i = 32'h99; bus.lo_i = 32'h88;
    #1;
    check("rst_rdata1", bus.rdata1, 32'h0);
    check("rst_hi_o", bus.hi_o, 32'h0);
    check("rst_lo_o", bus.lo_o, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      bus.re1 = 1'b1; bus.raddr1 = 5'(a);
      bus.re2 = 1'b1; bus.raddr2 = 5'(31 - a + 1);
      #1;
      check($sformatf("post_rst_r1_a%0d", a), bus.rdata1, 32'h0);
      check($sformatf("post_rst_r2_a%0d", 32 - a), bus.rdata2, 32'h0);
    end
    @(negedge clk);
    idle();
    #1;
    check("post_rst_hi_o", bus.hi_o, 32'h0);
    check("post_rst_lo_o", bus.lo_o, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_rdata1", i), bus.rdata1, vecs[i].e_r1);
      check($sformatf("v%0d_rdata2", i), bus.rdata2, vecs[i].e_r2);
      check($sformatf("v%0d_hi_o", i), bus.hi_o, vecs[i].e_hi);
      check($sformatf("v%0d_lo_o", i), bus.lo_o, vecs[i].e_lo);
    end

    // Async reset mid-operation.
    @(negedge clk);
    idle();
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h5A5A5A5A;
    bus.whilo = 1'b1; bus.hi_i = 32'h00000001; bus.lo_i = 32'h00000077;
    @(negedge clk);
    idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd9;
    bus.re2 = 1'b1; bus.raddr2 = 5'd9;
    #1;
    check("pre_arst_r1", bus.rdata1, 32'h5A5A5A5A);
    check("pre_arst_hi", bus.hi_o, 32'h00000001);
    check("pre_arst_lo", bus.lo_o, 32'h00000077);
    #1;
    rst = 1'b1;
    #1;
    check("arst_r1", bus.rdata1, 32'h0);
    check("arst_r2", bus.rdata2, 32'h0);
    check("arst_hi", bus.hi_o, 32'h0);
    check("arst_lo", bus.lo_o, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    check("arst_rel_r1", bus.rdata1, 32'h0);
    check("arst_rel_hi", bus.hi_o, 32'h0);
    @(negedge clk);
    #1;
    check("arst_after_r1", bus.rdata1, 32'h0);
    check("arst_after_r2", bus.rdata2, 32'h0);
    check("arst_after_hi", bus.hi_o, 32'h0);
    check("arst_after_lo", bus.lo_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
